// File: rtl/hex_scan_pkg.sv
// -----------------------------------------------------------------------------
// hex_scan_pkg
// Shared definitions for the four-digit hex scan controller:
//   - scan_state_t : scan FSM states (BLANK after reset, then DEAD/ON per slot)
//   - CLK_DIV_DEF  : default clock cycles per digit slot
//   - DEAD_CYC_DEF : default anode-off cycles at the start of each slot
//   - digit_sel    : pick nibble idx out of a 16-bit value
//   - anode_onehot : active-low one-hot anode pattern for digit idx
// -----------------------------------------------------------------------------
package hex_scan_pkg;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        DEAD  = 2'd1,
        ON    = 2'd2
    } scan_state_t;

    localparam int CLK_DIV_DEF  = 50000;
    localparam int DEAD_CYC_DEF = 16;

    function automatic logic [3:0] digit_sel(input logic [15:0] value,
                                             input logic [1:0]  idx);
        return value[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] anode_onehot(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Slot prescaler: counts 0..CLK_DIV-1 and wraps.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (counter to 0)
//   slot_end : high on the last count of a slot (CLK_DIV-1)
//   dead_end : high on the last dead count of a slot (DEAD_CYC-1)
// -----------------------------------------------------------------------------
module scan_tick_gen #(
    parameter int CLK_DIV  = 50000,
    parameter int DEAD_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_end,
    output logic dead_end
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign slot_end = (cnt_reg == CNT_LAST);
    assign dead_end = (cnt_reg == DEAD_LAST);

endmodule

// File: rtl/hex_scan_ctrl.sv
// -----------------------------------------------------------------------------
// hex_scan_ctrl
// Time-multiplexed four-digit hex display scanner with a one-deep load buffer
// that only updates the shown value at frame boundaries (no tearing), a dead
// time at the start of each slot, and optional leading-zero blanking.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   load_valid : producer offers load_data
//   load_data  : four hex digits, [15:12] = digit 3 ... [3:0] = digit 0
//   load_ready : a value can be accepted (pending buffer empty)
//   blank_en   : leading-zero blanking enable, sampled every cycle
//   nib        : nibble of the currently scanned digit
//   an_n       : active-low one-hot anode enables, an_n[i] = digit i
//   frame_tick : one-cycle pulse after each frame boundary
// -----------------------------------------------------------------------------
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int DEAD_CYC = DEAD_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    input  logic        blank_en,
    output logic [3:0]  nib,
    output logic [3:0]  an_n,
    output logic        frame_tick
);

    logic slot_end;
    logic dead_end;

    scan_tick_gen #(
        .CLK_DIV  (CLK_DIV),
        .DEAD_CYC (DEAD_CYC)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .slot_end (slot_end),
        .dead_end (dead_end)
    );

    scan_state_t state_reg, state_next;
    logic [1:0]  idx_reg, idx_next;
    logic [15:0] display_reg, display_next;
    logic [15:0] pending_reg, pending_next;
    logic        pend_valid_reg, pend_valid_next;
    logic        load_ready_reg;
    logic [3:0]  an_n_reg, an_n_next;
    logic [3:0]  nib_reg, nib_next;
    logic        frame_tick_reg, frame_tick_next;
    logic        accept;
    logic        frame_end;
    logic [3:0]  lead_zero;

    assign accept    = load_valid & load_ready_reg;
    // The slot that closes BLANK counts as a frame boundary as well.
    assign frame_end = slot_end & ((state_reg == BLANK) | (idx_reg == 2'd3));

    // Sequencing and load buffer.
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        display_next    = display_reg;
        pending_next    = pending_reg;
        pend_valid_next = pend_valid_reg;
        frame_tick_next = frame_end;

        case (state_reg)
            BLANK: if (slot_end) begin
                state_next = DEAD;
                idx_next   = 2'd0;
            end
            DEAD:  if (dead_end) state_next = ON;
            ON:    if (slot_end) state_next = DEAD;
            default: state_next = BLANK;
        endcase

        if (slot_end && state_reg != BLANK) begin
            idx_next = idx_reg + 2'd1;
        end

        if (frame_end && pend_valid_reg) begin
            display_next    = pending_reg;
            pend_valid_next = 1'b0;
        end

        // accept needs pend_valid clear, so it never collides with a transfer.
        if (accept) begin
            pending_next    = load_data;
            pend_valid_next = 1'b1;
        end
    end

    // lead_zero[i]: digit i and every more-significant digit are zero.
    // Digit 0 is never blanked so a zero value still shows one "0".
    assign lead_zero[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lead_zero
            assign lead_zero[gi] = (display_next[15:gi*4] == '0);
        end
    endgenerate

    // Outputs are computed from the next state so they switch on the same
    // edge as the FSM, index and display register.
    always_comb begin
        an_n_next = 4'b1111;
        nib_next  = 4'h0;
        if (state_next != BLANK) begin
            nib_next = digit_sel(display_next, idx_next);
        end
        if (state_next == ON && !(blank_en && lead_zero[idx_next])) begin
            an_n_next = anode_onehot(idx_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= BLANK;
            idx_reg        <= 2'd0;
            display_reg    <= 16'h0000;
            pending_reg    <= 16'h0000;
            pend_valid_reg <= 1'b0;
            load_ready_reg <= 1'b1;
            an_n_reg       <= 4'b1111;
            nib_reg        <= 4'h0;
            frame_tick_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            display_reg    <= display_next;
            pending_reg    <= pending_next;
            pend_valid_reg <= pend_valid_next;
            load_ready_reg <= ~pend_valid_next;
            an_n_reg       <= an_n_next;
            nib_reg        <= nib_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign load_ready = load_ready_reg;
    assign an_n       = an_n_reg;
    assign nib        = nib_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hex_scan_ctrl
// Directed bench, CLK_DIV = 8, DEAD_CYC = 2. cyc counts rising edges since
// reset release; outputs are sampled on the falling edge. Slot 0 (cyc 0..7)
// is BLANK, then frame f covers cyc 8+32f .. 39+32f with index k slot at
// 8+32f+8k; ON begins two cycles into each slot.
// -----------------------------------------------------------------------------
module tb_hex_scan_ctrl;

    localparam int CLK_DIV  = 8;
    localparam int DEAD_CYC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic        blank_en = 1'b0;
    logic        load_ready;
    logic [3:0]  nib;
    logic [3:0]  an_n;
    logic        frame_tick;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    hex_scan_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .DEAD_CYC (DEAD_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .blank_en   (blank_en),
        .nib        (nib),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] exp_an,
                            input logic [3:0] exp_nib);
        check_eq({tag, "_an"}, 32'(an_n), 32'(exp_an));
        check_eq({tag, "_nib"}, 32'(nib), 32'(exp_nib));
    endtask

    task automatic offer(input logic [15:0] data);
        load_data  = data;
        load_valid = 1'b1;
        $display("cyc %0d: offer load_data=%h load_ready=%b", cyc, data, load_ready);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check_eq("rst_an", 32'(an_n), 32'hF);
        check_eq("rst_nib", 32'(nib), 32'h0);
        check_eq("rst_ready", 32'(load_ready), 32'h1);
        check_eq("rst_tick", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;
        cyc   = 0;
        $display("cyc %0d: reset released", cyc);

        // BLANK slot then first DEAD/ON.
        check_eq("blank_an0", 32'(an_n), 32'hF);
        goto(7);  check_eq("blank_an7", 32'(an_n), 32'hF);
                  check_eq("blank_tick7", 32'(frame_tick), 32'h0);
        goto(8);  check_eq("blank_end_tick", 32'(frame_tick), 32'h1);
                  check_eq("dead0_an", 32'(an_n), 32'hF);
        goto(9);  check_eq("tick_one_cycle", 32'(frame_tick), 32'h0);
                  check_eq("dead1_an", 32'(an_n), 32'hF);
        goto(10); chk_disp("on_first", 4'b1110, 4'h0);
                  check_eq("idle_ready", 32'(load_ready), 32'h1);
                  offer(16'h1A3F);
        goto(11); check_eq("ready_fall", 32'(load_ready), 32'h0);
                  load_valid = 1'b0;
        goto(15); check_eq("on_last_an", 32'(an_n), 32'hE);
        goto(34); chk_disp("no_tear", 4'b0111, 4'h0);
        goto(39); check_eq("pre_frame_tick", 32'(frame_tick), 32'h0);
        goto(40); check_eq("frame1_tick", 32'(frame_tick), 32'h1);
                  check_eq("frame1_ready", 32'(load_ready), 32'h1);
                  chk_disp("frame1_dead", 4'b1111, 4'hF);

        // Back-pressure: 1234 accepted, 5678 held off until the transfer.
        goto(41); offer(16'h1234);
        goto(42); check_eq("bp_ready_fall", 32'(load_ready), 32'h0);
                  load_valid = 1'b0;
                  chk_disp("d0_1A3F", 4'b1110, 4'hF);
        goto(50); chk_disp("d1_1A3F", 4'b1101, 4'h3);
                  offer(16'h5678);
        goto(58); chk_disp("d2_1A3F", 4'b1011, 4'hA);
        goto(66); chk_disp("d3_1A3F", 4'b0111, 4'h1);
        goto(71); check_eq("bp_ready_low", 32'(load_ready), 32'h0);
        goto(72); check_eq("bp_ready_rise", 32'(load_ready), 32'h1);
                  check_eq("frame2_tick", 32'(frame_tick), 32'h1);
        goto(73); check_eq("bp_second_acc", 32'(load_ready), 32'h0);
                  load_valid = 1'b0;
        goto(74); chk_disp("d0_1234", 4'b1110, 4'h4);
        goto(82); chk_disp("d1_1234", 4'b1101, 4'h3);
        goto(98); chk_disp("d3_1234", 4'b0111, 4'h1);
        goto(100); check_eq("bp_pending_full", 32'(load_ready), 32'h0);
        goto(106); chk_disp("d0_5678", 4'b1110, 4'h8);
        goto(130); chk_disp("d3_5678", 4'b0111, 4'h5);

        // Load offered exactly on the frame-boundary cycle.
        goto(135); check_eq("edge_ready", 32'(load_ready), 32'h1);
                   offer(16'h0040);
        goto(136); check_eq("edge_accepted", 32'(load_ready), 32'h0);
                   check_eq("frame4_tick", 32'(frame_tick), 32'h1);
                   load_valid = 1'b0;
                   blank_en   = 1'b1;
        goto(138); chk_disp("edge_not_yet", 4'b1110, 4'h8);

        // Blanking on 0040 then 0000.
        goto(170); chk_disp("blk_0040_d0", 4'b1110, 4'h0);
                   offer(16'h0000);
        goto(171); check_eq("zero_accepted", 32'(load_ready), 32'h0);
                   load_valid = 1'b0;
        goto(178); chk_disp("blk_0040_d1", 4'b1101, 4'h4);
        goto(186); chk_disp("blk_0040_d2", 4'b1111, 4'h0);
        goto(194); chk_disp("blk_0040_d3", 4'b1111, 4'h0);
        goto(200); check_eq("frame6_tick", 32'(frame_tick), 32'h1);
        goto(202); chk_disp("blk_0000_d0", 4'b1110, 4'h0);
        goto(210); check_eq("blk_0000_d1", 32'(an_n), 32'hF);
        goto(218); check_eq("blk_0000_d2", 32'(an_n), 32'hF);
        goto(226); check_eq("blk_0000_d3", 32'(an_n), 32'hF);
                   blank_en = 1'b0;
        goto(228); chk_disp("noblk_0000_d3", 4'b0111, 4'h0);
                   offer(16'hCAFE);
        goto(229); check_eq("cafe_accepted", 32'(load_ready), 32'h0);
                   load_valid = 1'b0;
        goto(234); check_eq("pre_rst_on", 32'(an_n), 32'hE);

        // Mid-frame asynchronous reset, checked before the next clock edge.
        #2;
        rst_n = 1'b0;
        $display("cyc %0d: reset asserted mid-slot", cyc);
        #1;
        check_eq("arst_an", 32'(an_n), 32'hF);
        check_eq("arst_nib", 32'(nib), 32'h0);
        check_eq("arst_ready", 32'(load_ready), 32'h1);
        check_eq("arst_tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        $display("cyc %0d: reset released", cyc);
        goto(7);  check_eq("re_blank_an", 32'(an_n), 32'hF);
        goto(8);  check_eq("re_blank_tick", 32'(frame_tick), 32'h1);
        goto(10); chk_disp("pending_lost", 4'b1110, 4'h0);
                  check_eq("re_ready", 32'(load_ready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
